// File: rtl/tdm_bus_demux.sv
// Receive side of the TDM shared bus: slices each frame round-robin onto N_CH registered channels.
// Latency 1 cycle bus->channel; a busy channel (valid & !ready) drops its word and flags overrun.
module tdm_bus_demux #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        bus_data,
  input  logic                bus_valid,
  input  logic                frame_start,
  input  logic [N_CH-1:0]     ch_ready,
  input  logic                clr_err,
  output logic [N_CH*W-1:0]   ch_data,
  output logic [N_CH-1:0]     ch_valid,
  output logic [SEL_W-1:0]    cur_slot,
  output logic                busy,
  output logic                frame_done,
  output logic [N_CH-1:0]     overrun,
  output logic                short_frame,
  output logic                sync_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] slot_nxt, wslot;
  logic             cap, short_ev, sync_ev, last_cap;
  logic [N_CH-1:0]  wr, ovr_ev;

  always_comb begin
    state_nxt = state;
    slot_nxt  = cur_slot;
    wslot     = cur_slot;
    cap       = 1'b0;
    short_ev  = 1'b0;
    sync_ev   = 1'b0;
    if (frame_start) begin
      // A frame_start always restarts at slot 0, from IDLE or mid-frame.
      state_nxt = RUN;
      slot_nxt  = '0;
      wslot     = '0;
      short_ev  = (state == RUN) && (cur_slot != '0);
      if (bus_valid) begin
        cap      = 1'b1;
        slot_nxt = SEL_W'(1);
      end
    end else if (state == RUN) begin
      if (bus_valid) begin
        cap = 1'b1;
        if (cur_slot == SEL_W'(N_CH - 1)) begin
          state_nxt = IDLE;
          slot_nxt  = '0;
        end else begin
          slot_nxt = cur_slot + SEL_W'(1);
        end
      end
    end else begin
      sync_ev = bus_valid;
    end
    last_cap = cap && (wslot == SEL_W'(N_CH - 1));
  end

  always_comb begin
    wr     = '0;
    ovr_ev = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cap && (wslot == SEL_W'(i))) begin
        if (!ch_valid[i] || ch_ready[i]) wr[i] = 1'b1;
        else                             ovr_ev[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_slot    <= '0;
      frame_done  <= 1'b0;
      overrun     <= '0;
      short_frame <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_slot    <= slot_nxt;
      frame_done  <= last_cap;
      // New events take priority over a same-cycle clear.
      overrun     <= (overrun & ~{N_CH{clr_err}}) | ovr_ev;
      short_frame <= (short_frame & ~clr_err) | short_ev;
      sync_err    <= (sync_err & ~clr_err) | sync_ev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_data  <= '0;
      ch_valid <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr[i]) begin
          ch_data[i*W +: W] <= bus_data;
          ch_valid[i]       <= 1'b1;
        end else if (ch_valid[i] && ch_ready[i]) begin
          ch_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_tdm_bus_demux.sv
// Directed bench for tdm_bus_demux (N_CH=4, W=8): one task per scenario with inline checks.
module tb_tdm_bus_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  bus_data;
  logic        bus_valid;
  logic        frame_start;
  logic [3:0]  ch_ready;
  logic        clr_err;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid;
  logic [1:0]  cur_slot;
  logic        busy;
  logic        frame_done;
  logic [3:0]  overrun;
  logic        short_frame;
  logic        sync_err;

  int total = 0;
  int bad   = 0;

  tdm_bus_demux #(.N_CH(4), .W(8), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus_data(bus_data), .bus_valid(bus_valid),
    .frame_start(frame_start), .ch_ready(ch_ready), .clr_err(clr_err),
    .ch_data(ch_data), .ch_valid(ch_valid), .cur_slot(cur_slot), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .short_frame(short_frame),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic v, input logic [7:0] d);
    frame_start = fs;
    bus_valid   = v;
    bus_data    = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive(1'b0, 1'b0, 8'h00); ch_ready = 4'hF; clr_err = 1'b0;
    #3;
    total++; if (ch_valid !== 4'h0) begin bad++; $display("FAIL reset_valid got=%h exp=0", ch_valid); end
    total++; if (ch_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", ch_data); end
    total++; if ({busy, frame_done, short_frame, sync_err, overrun, cur_slot} !== 10'h0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {busy, frame_done, short_frame, sync_err, overrun, cur_slot}); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_nominal();
    ch_ready = 4'hF;
    drive(1'b1, 1'b1, 8'hA0); cyc();
    total++; if (ch_valid !== 4'b0001 || busy !== 1'b1 || cur_slot !== 2'd1) begin
      bad++; $display("FAIL nom_slot0 valid=%b busy=%b slot=%0d exp 0001/1/1", ch_valid, busy, cur_slot); end
    drive(1'b0, 1'b1, 8'hA1); cyc();
    total++; if (ch_valid !== 4'b0010) begin bad++; $display("FAIL nom_slot1 valid=%b exp=0010", ch_valid); end
    drive(1'b0, 1'b1, 8'hA2); cyc();
    total++; if (ch_valid !== 4'b0100 || frame_done !== 1'b0) begin
      bad++; $display("FAIL nom_slot2 valid=%b done=%b exp 0100/0", ch_valid, frame_done); end
    drive(1'b0, 1'b1, 8'hA3); cyc();
    total++; if (ch_data !== 32'hA3A2A1A0) begin bad++; $display("FAIL nom_data got=%h exp=a3a2a1a0", ch_data); end
    total++; if (ch_valid !== 4'b1000 || frame_done !== 1'b1 || busy !== 1'b0 || cur_slot !== 2'd0) begin
      bad++; $display("FAIL nom_end valid=%b done=%b busy=%b slot=%0d exp 1000/1/0/0", ch_valid, frame_done, busy, cur_slot); end
    drive(1'b0, 1'b0, 8'h00); cyc();
    total++; if (frame_done !== 1'b0 || ch_valid !== 4'h0) begin
      bad++; $display("FAIL nom_pulse done=%b valid=%b exp 0/0000", frame_done, ch_valid); end
    total++; if ({overrun, short_frame, sync_err} !== 6'h0) begin
      bad++; $display("FAIL nom_err got=%b exp=0", {overrun, short_frame, sync_err}); end
  endtask

  task automatic test_backpressure();
    ch_ready = 4'b1011;
    drive(1'b1, 1'b1, 8'hB0); cyc();
    drive(1'b0, 1'b1, 8'hB1); cyc();
    drive(1'b0, 1'b1, 8'h11); cyc();
    drive(1'b0, 1'b1, 8'hB3); cyc();
    drive(1'b1, 1'b1, 8'hC0); cyc();
    drive(1'b0, 1'b1, 8'hC1); cyc();
    drive(1'b0, 1'b1, 8'h22); cyc();
    total++; if (overrun !== 4'b0100) begin bad++; $display("FAIL bp_overrun got=%b exp=0100", overrun); end
    total++; if (ch_data[23:16] !== 8'h11 || ch_valid[2] !== 1'b1) begin
      bad++; $display("FAIL bp_hold data=%h valid=%b exp 11/1", ch_data[23:16], ch_valid[2]); end
    drive(1'b0, 1'b1, 8'hC3); cyc();
    ch_ready = 4'hF; drive(1'b0, 1'b0, 8'h00); cyc();
    total++; if (ch_valid !== 4'h0) begin bad++; $display("FAIL bp_drain valid=%b exp=0000", ch_valid); end
    total++; if (overrun !== 4'b0100) begin bad++; $display("FAIL bp_sticky got=%b exp=0100", overrun); end
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    total++; if (overrun !== 4'h0) begin bad++; $display("FAIL bp_clear got=%b exp=0000", overrun); end
  endtask

  task automatic test_short_frame();
    ch_ready = 4'hF;
    drive(1'b1, 1'b1, 8'h01); cyc();
    drive(1'b0, 1'b1, 8'h02); cyc();
    drive(1'b1, 1'b1, 8'h03); cyc();
    total++; if (short_frame !== 1'b1) begin bad++; $display("FAIL short_flag got=%b exp=1", short_frame); end
    total++; if (ch_data[7:0] !== 8'h03 || ch_data[15:8] !== 8'h02 || ch_valid[0] !== 1'b1) begin
      bad++; $display("FAIL short_data ch0=%h ch1=%h v0=%b exp 03/02/1", ch_data[7:0], ch_data[15:8], ch_valid[0]); end
    total++; if (cur_slot !== 2'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL short_slot slot=%0d busy=%b exp 1/1", cur_slot, busy); end
    drive(1'b0, 1'b1, 8'h04); cyc();
    drive(1'b0, 1'b1, 8'h05); cyc();
    drive(1'b0, 1'b1, 8'h06); cyc();
    total++; if (ch_data !== 32'h06050403 || frame_done !== 1'b1) begin
      bad++; $display("FAIL short_finish data=%h done=%b exp 06050403/1", ch_data, frame_done); end
    drive(1'b0, 1'b0, 8'h00); clr_err = 1'b1; cyc(); clr_err = 1'b0;
    total++; if (short_frame !== 1'b0) begin bad++; $display("FAIL short_clear got=%b exp=0", short_frame); end
  endtask

  task automatic test_stray();
    ch_ready = 4'hF;
    drive(1'b0, 1'b1, 8'hFF); cyc();
    total++; if (ch_valid !== 4'h0 || sync_err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL stray_drop valid=%b sync=%b busy=%b exp 0000/1/0", ch_valid, sync_err, busy); end
    clr_err = 1'b1; cyc();
    total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL stray_clr_race got=%b exp=1", sync_err); end
    drive(1'b0, 1'b0, 8'h00); cyc(); clr_err = 1'b0;
    total++; if (sync_err !== 1'b0 || ch_data !== 32'h06050403) begin
      bad++; $display("FAIL stray_clear sync=%b data=%h exp 0/06050403", sync_err, ch_data); end
  endtask

  task automatic test_gaps();
    ch_ready = 4'h0;
    drive(1'b1, 1'b1, 8'hD0); cyc();
    drive(1'b0, 1'b0, 8'hzz); cyc();
    total++; if (cur_slot !== 2'd1 || ch_valid !== 4'b0001 || ch_data[7:0] !== 8'hD0) begin
      bad++; $display("FAIL gap_first slot=%0d valid=%b d0=%h exp 1/0001/d0", cur_slot, ch_valid, ch_data[7:0]); end
    drive(1'b0, 1'b1, 8'hD1); cyc();
    drive(1'b0, 1'b0, 8'hzz); cyc(); cyc();
    total++; if (cur_slot !== 2'd2 || ^ch_data === 1'bx) begin
      bad++; $display("FAIL gap_mid slot=%0d data=%h exp slot 2 no X", cur_slot, ch_data); end
    drive(1'b0, 1'b1, 8'hD2); cyc();
    drive(1'b0, 1'b0, 8'hzz); cyc();
    drive(1'b0, 1'b1, 8'hD3); cyc();
    drive(1'b0, 1'b0, 8'hzz);
    total++; if (ch_data !== 32'hD3D2D1D0 || ch_valid !== 4'hF || frame_done !== 1'b1) begin
      bad++; $display("FAIL gap_end data=%h valid=%b done=%b exp d3d2d1d0/1111/1", ch_data, ch_valid, frame_done); end
    total++; if (^{ch_data, ch_valid, cur_slot, busy, frame_done, overrun, short_frame, sync_err} === 1'bx || overrun !== 4'h0) begin
      bad++; $display("FAIL gap_nox overrun=%b data=%h exp no X, overrun 0", overrun, ch_data); end
    ch_ready = 4'hF; cyc();
  endtask

  task automatic test_reset_mid();
    ch_ready = 4'h0;
    drive(1'b1, 1'b1, 8'hE0); cyc();
    drive(1'b0, 1'b1, 8'hE1); cyc();
    drive(1'b0, 1'b0, 8'h00);
    total++; if (cur_slot !== 2'd2 || ch_valid !== 4'b0011) begin
      bad++; $display("FAIL rmid_pre slot=%0d valid=%b exp 2/0011", cur_slot, ch_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (ch_data !== 32'h0 || ch_valid !== 4'h0 || cur_slot !== 2'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_async data=%h valid=%b slot=%0d busy=%b exp all 0", ch_data, ch_valid, cur_slot, busy); end
    total++; if ({frame_done, overrun, short_frame, sync_err} !== 7'h0) begin
      bad++; $display("FAIL rmid_flags got=%b exp=0", {frame_done, overrun, short_frame, sync_err}); end
    cyc();
    rst_n = 1'b1;
    ch_ready = 4'hF;
    drive(1'b0, 1'b1, 8'h55); cyc();
    total++; if (busy !== 1'b0 || ch_valid !== 4'h0 || sync_err !== 1'b1) begin
      bad++; $display("FAIL rmid_idle busy=%b valid=%b sync=%b exp 0/0000/1", busy, ch_valid, sync_err); end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_short_frame();
    test_stray();
    test_gaps();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
